// File: rtl/mc_pkg.sv
// Shared multicycle-core definitions: IR field layout, opcodes, fetch FSM.
// Imported by the fetch stage and the field decoder.
package mc_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JT_MSB     = 25;
  localparam int JT_LSB     = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational slicing of the instruction register into fields.
// Reusable by the main decoder.
module instr_field_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jump_target
);

  assign opcode      = ir[OPCODE_MSB:OPCODE_LSB];
  assign rs          = ir[RS_MSB:RS_LSB];
  assign rt          = ir[RT_MSB:RT_LSB];
  assign rd          = ir[RD_MSB:RD_LSB];
  assign shamt       = ir[SHAMT_MSB:SHAMT_LSB];
  assign funct       = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm16       = ir[IMM_MSB:IMM_LSB];
  assign jump_target = ir[JT_MSB:JT_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage + instruction register feeding sign_extend.
// Optional wait timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import mc_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic              ir_flush,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              ir_valid,
  output logic              addr_misaligned,
  output logic [ADDR_W-1:0] pc_plus4,
`ifdef FETCH_TIMEOUT_EN
  output logic              fetch_error,
`endif
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       jump_target
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic              busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       ferr_q, ferr_d;
`endif

  // Next-state and registered-output logic of the fetch FSM.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
`endif
    if (ir_flush) begin
      state_d = S_IDLE;
      ir_d    = DATA_W'(NOP_WORD);
      valid_d = 1'b0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fetch_start) begin
            if (pc_in[1:0] != 2'b00) begin
              mis_d = 1'b1;
            end else begin
              addr_d  = pc_in;
              req_d   = 1'b1;
              valid_d = 1'b0;
              state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
              cnt_d   = 8'd0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            ir_d    = mem_rdata;
            pc4_d   = addr_q + ADDR_W'(4);
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == TO_LIM) begin
            req_d   = 1'b0;
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_WAIT);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= DATA_W'(NOP_WORD);
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait-cycle counter and one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      ferr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ferr_q <= ferr_d;
    end
  end

  assign fetch_error = ferr_q;
`endif

  assign mem_req         = req_q;
  assign mem_addr        = addr_q;
  assign busy            = busy_q;
  assign ir_valid        = valid_q;
  assign addr_misaligned = mis_q;
  assign pc_plus4        = pc4_q;

  instr_field_decode u_dec (
    .ir          (ir_q[31:0]),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .jump_target (jump_target)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, corner
// sequences and random traffic against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        ir_flush = 1'b0;
  logic [31:0] pc_in = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        ir_valid;
  logic        addr_misaligned;
  logic [31:0] pc_plus4;
  logic        fetch_error;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jump_target;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

`ifndef FETCH_TIMEOUT_EN
  assign fetch_error = 1'b0;
`endif

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_start(fetch_start), .ir_flush(ir_flush),
    .pc_in(pc_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .ir_valid(ir_valid),
    .addr_misaligned(addr_misaligned), .pc_plus4(pc_plus4),
`ifdef FETCH_TIMEOUT_EN
    .fetch_error(fetch_error),
`endif
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm16),
    .jump_target(jump_target)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fields are defined as bit ranges of the instruction word.
  task automatic chk_fields(string tag, logic [31:0] w);
    chk({tag, ".opcode"}, 32'(opcode), 32'(w[31:26]));
    chk({tag, ".rs"},     32'(rs),     32'(w[25:21]));
    chk({tag, ".rt"},     32'(rt),     32'(w[20:16]));
    chk({tag, ".rd"},     32'(rd),     32'(w[15:11]));
    chk({tag, ".shamt"},  32'(shamt),  32'(w[10:6]));
    chk({tag, ".funct"},  32'(funct),  32'(w[5:0]));
    chk({tag, ".imm16"},  32'(imm16),  32'(w[15:0]));
    chk({tag, ".jt"},     32'(jump_target), 32'(w[25:0]));
  endtask

  task automatic drive(logic fs, logic fl, logic [31:0] pc,
                       logic ack, logic [31:0] rd_w);
    fetch_start = fs;
    ir_flush    = fl;
    pc_in       = pc;
    mem_ack     = ack;
    mem_rdata   = rd_w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one outstanding fetch at most.
  bit          m_pending;
  int          m_waited;
  logic [31:0] m_ir, m_addr, m_pc4;
  bit          m_valid, m_mis, m_ferr;

  function automatic void m_reset();
    m_pending = 0; m_waited = 0; m_ir = '0; m_addr = '0;
    m_pc4 = '0; m_valid = 0; m_mis = 0; m_ferr = 0;
  endfunction

  function automatic void m_step(bit fs, bit fl, logic [31:0] pc,
                                 bit ack, logic [31:0] rd_w);
    m_mis  = 0;
    m_ferr = 0;
    if (fl) begin
      m_pending = 0; m_ir = '0; m_valid = 0;
    end else if (m_pending) begin
      if (ack) begin
        m_pending = 0; m_ir = rd_w; m_valid = 1;
        m_pc4 = m_addr + 32'd4;
      end else begin
`ifdef FETCH_TIMEOUT_EN
        if (m_waited == TO) begin
          m_pending = 0; m_ferr = 1;
        end else m_waited++;
`endif
      end
    end else if (fs) begin
      if (pc % 4 != 0) m_mis = 1;
      else begin
        m_pending = 1; m_waited = 0; m_addr = pc; m_valid = 0;
      end
    end
  endfunction

  task automatic chk_model(string tag);
    chk({tag, ".req"},   32'(mem_req),  32'(m_pending));
    chk({tag, ".busy"},  32'(busy),     32'(m_pending));
    chk({tag, ".addr"},  mem_addr,      m_addr);
    chk({tag, ".valid"}, 32'(ir_valid), 32'(m_valid));
    chk({tag, ".mis"},   32'(addr_misaligned), 32'(m_mis));
    chk({tag, ".pc4"},   pc_plus4,      m_pc4);
    chk({tag, ".ferr"},  32'(fetch_error), 32'(m_ferr));
    chk_fields(tag, m_ir);
  endtask

  typedef struct {
    logic        fs, fl;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    logic        req, bsy, vld, mis;
    logic [31:0] addr, ir, pc4;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic fs, logic fl, logic [31:0] pc,
                              logic ack, logic [31:0] rd_w,
                              logic req, logic bsy, logic vld,
                              logic mis, logic [31:0] addr,
                              logic [31:0] ir, logic [31:0] pc4);
    vec_t v;
    v.fs = fs; v.fl = fl; v.pc = pc; v.ack = ack; v.rd = rd_w;
    v.req = req; v.bsy = bsy; v.vld = vld; v.mis = mis;
    v.addr = addr; v.ir = ir; v.pc4 = pc4;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1,0,32'h40,0,0,             1,1,0,0,32'h40,32'h0,32'h0);
    tbl[1]  = mk(0,0,0,1,32'h2128FFFF,       0,0,1,0,32'h40,32'h2128FFFF,32'h44);
    tbl[2]  = mk(1,0,32'h100,0,0,            1,1,0,0,32'h100,32'h2128FFFF,32'h44);
    tbl[3]  = mk(0,0,0,0,0,                  1,1,0,0,32'h100,32'h2128FFFF,32'h44);
    tbl[4]  = mk(0,0,0,0,0,                  1,1,0,0,32'h100,32'h2128FFFF,32'h44);
    tbl[5]  = mk(0,0,0,0,0,                  1,1,0,0,32'h100,32'h2128FFFF,32'h44);
    tbl[6]  = mk(0,0,0,1,32'h8D097FFF,       0,0,1,0,32'h100,32'h8D097FFF,32'h104);
    tbl[7]  = mk(1,0,32'h42,0,0,             0,0,1,1,32'h100,32'h8D097FFF,32'h104);
    tbl[8]  = mk(0,0,0,0,0,                  0,0,1,0,32'h100,32'h8D097FFF,32'h104);
    tbl[9]  = mk(0,0,0,1,32'hDEADBEEF,       0,0,1,0,32'h100,32'h8D097FFF,32'h104);
    tbl[10] = mk(1,0,32'h200,0,0,            1,1,0,0,32'h200,32'h8D097FFF,32'h104);
    tbl[11] = mk(0,1,0,1,32'hFFFFFFFF,       0,0,0,0,32'h200,32'h0,32'h104);
    tbl[12] = mk(1,0,32'hFFFFFFFC,0,0,       1,1,0,0,32'hFFFFFFFC,32'h0,32'h104);
    tbl[13] = mk(0,0,0,1,32'h08000010,       0,0,1,0,32'hFFFFFFFC,32'h08000010,32'h0);
    tbl[14] = mk(1,1,32'h300,0,0,            0,0,0,0,32'hFFFFFFFC,32'h0,32'h0);
    tbl[15] = mk(1,0,32'h300,0,0,            1,1,0,0,32'h300,32'h0,32'h0);
    tbl[16] = mk(1,0,32'h400,0,0,            1,1,0,0,32'h300,32'h0,32'h0);
    tbl[17] = mk(0,0,0,1,32'h00001234,       0,0,1,0,32'h300,32'h1234,32'h304);

    // Reset state.
    repeat (2) tick();
    chk("rst.req",   32'(mem_req), 0);
    chk("rst.addr",  mem_addr, 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.valid", 32'(ir_valid), 0);
    chk("rst.mis",   32'(addr_misaligned), 0);
    chk("rst.pc4",   pc_plus4, 0);
    chk("rst.ferr",  32'(fetch_error), 0);
    chk_fields("rst", 32'h0);
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fs, tbl[i].fl, tbl[i].pc, tbl[i].ack, tbl[i].rd);
      tick();
      chk($sformatf("v%0d.req", i),   32'(mem_req),  32'(tbl[i].req));
      chk($sformatf("v%0d.busy", i),  32'(busy),     32'(tbl[i].bsy));
      chk($sformatf("v%0d.valid", i), 32'(ir_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d.mis", i),   32'(addr_misaligned), 32'(tbl[i].mis));
      chk($sformatf("v%0d.addr", i),  mem_addr, tbl[i].addr);
      chk($sformatf("v%0d.pc4", i),   pc_plus4, tbl[i].pc4);
      chk_fields($sformatf("v%0d", i), tbl[i].ir);
      if (i == 1) begin
        chk("zw.opcode", 32'(opcode), 32'h08);
        chk("zw.rs",     32'(rs), 9);
        chk("zw.rt",     32'(rt), 8);
        chk("zw.imm16",  32'(imm16), 32'hFFFF);
      end
      if (i == 6) begin
        chk("w3.opcode", 32'(opcode), 32'h23);
        chk("w3.rs",     32'(rs), 8);
        chk("w3.rt",     32'(rt), 9);
        chk("w3.imm16",  32'(imm16), 32'h7FFF);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();

    // Async reset in the middle of a wait, then a stray ack.
    drive(1, 0, 32'h500, 0, 0);
    tick();
    chk("ar.req_before", 32'(mem_req), 1);
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.req",   32'(mem_req), 0);
    chk("ar.busy",  32'(busy), 0);
    chk("ar.addr",  mem_addr, 0);
    chk("ar.pc4",   pc_plus4, 0);
    chk("ar.valid", 32'(ir_valid), 0);
    chk_fields("ar", 32'h0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 32'hFFFFFFFF);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("ar.stray_valid", 32'(ir_valid), 0);
    chk("ar.stray_req",   32'(mem_req), 0);
    chk_fields("ar.stray", 32'h0);

    // Random traffic against the reference model.
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        fs, fl, ack;
      logic [31:0] pc, rdw;
      fs  = ($urandom % 3) == 0;
      fl  = ($urandom % 20) == 0;
      ack = ($urandom % 3) == 0;
      pc  = $urandom;
      if (($urandom % 6) != 0) pc[1:0] = 2'b00;
      rdw = $urandom;
      drive(fs, fl, pc, ack, rdw);
      m_step(fs, fl, pc, ack, rdw);
      tick();
      chk_model($sformatf("r%0d", c));
    end
    drive(0, 0, 0, 0, 0);

`ifdef FETCH_TIMEOUT_EN
    // Never acknowledge: abort after the limit.
    drive(0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 32'h10, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("to%0d.req", k),  32'(mem_req), 32'(k < 5));
      chk($sformatf("to%0d.ferr", k), 32'(fetch_error), 32'(k == 5));
      chk($sformatf("to%0d.valid", k), 32'(ir_valid), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
